lv_owt_req_arb: RTL and testbench

LV_OWT_REQ_ARB -- requirements
Module: lv_owt_req_arb

---
 rtl/lv_pkg.sv | 23 ++
 rtl/lv_rr_arb2.sv | 29 ++
 rtl/lv_owt_req_arb.sv | 165 ++++++++++++++++
 tb/tb_lv_owt_req_arb.sv | 457 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lv_pkg.sv
// Shared one-wire-transaction types and constants: arbiter FSM states,
// ADC poll command and default timing/retry limits.
package lv_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARB     = 3'd1,
        ST_TX      = 3'd2,
        ST_WAIT_RX = 3'd3,
        ST_RESP    = 3'd4
    } lv_owt_arb_st_e;

    // Read of register 0x1F: the ADC result register.
    localparam logic [7:0] ADC_POLL_CMD = 8'h1F;

    localparam int OWT_TMO_CYC_DEF   = 255;
    localparam int OWT_RETRY_MAX_DEF = 2;

    // Requester indices shared by the arbiter and the request mux.
    localparam logic RR_SPI = 1'b0;
    localparam logic RR_ADC = 1'b1;

endpackage

// File: rtl/lv_rr_arb2.sv
// Two-requester round-robin arbiter: the requester not served last wins a tie;
// the last-served pointer moves only when i_upd_en is high.
module lv_rr_arb2
    import lv_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [1:0] i_req,
    input  logic       i_upd_en,
    input  logic       i_upd_idx,
    output logic       o_gnt_vld,
    output logic       o_gnt_idx
);

    logic last_q;

    // NOTE: non-blocking assignment so every register samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            last_q <= RR_ADC;
        end else if (i_upd_en) begin
            last_q <= i_upd_idx;
        end
    end

    assign o_gnt_vld = |i_req;
    assign o_gnt_idx = (&i_req) ? ~last_q : i_req[1];

endmodule

// File: rtl/lv_owt_req_arb.sv
// Arbitrates SPI and ADC-poll requests onto one one-wire TX/RX channel.
// Define LV_OWT_RETRY_EN to resend a failed frame up to OWT_RETRY_MAX times.
module lv_owt_req_arb
    import lv_pkg::*;
#(
    parameter int OWT_CMD_BIT_NUM  = 8,
    parameter int OWT_DATA_BIT_NUM = 8,
    parameter int OWT_ADCD_BIT_NUM = 10,
    parameter int OWT_TMO_CYC      = OWT_TMO_CYC_DEF,
    parameter int OWT_RETRY_MAX    = OWT_RETRY_MAX_DEF
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_spi_req,
    input  logic [OWT_CMD_BIT_NUM-1:0]  i_spi_cmd,
    input  logic [OWT_DATA_BIT_NUM-1:0] i_spi_wdata,
    output logic                        o_spi_done,
    output logic [OWT_DATA_BIT_NUM-1:0] o_spi_rdata,
    output logic                        o_spi_err,
    input  logic                        i_adc_req,
    output logic                        o_adc_done,
    output logic [OWT_ADCD_BIT_NUM-1:0] o_adc_data,
    output logic                        o_adc_err,
    output logic                        o_owt_tx_req,
    output logic [OWT_CMD_BIT_NUM-1:0]  o_owt_tx_cmd,
    output logic [OWT_ADCD_BIT_NUM-1:0] o_owt_tx_data,
    input  logic                        i_owt_tx_done,
    input  logic                        i_owt_rx_ack,
    input  logic                        i_owt_rx_status,
    input  logic [OWT_CMD_BIT_NUM-1:0]  i_owt_rx_cmd,
    input  logic [OWT_ADCD_BIT_NUM-1:0] i_owt_rx_data
);

    localparam logic [7:0] TMO_LAST = 8'(OWT_TMO_CYC - 1);

    lv_owt_arb_st_e state_q, state_d;

    logic [OWT_CMD_BIT_NUM-1:0]  cmd_q;
    logic [OWT_ADCD_BIT_NUM-1:0] data_q;
    logic                        gnt_q;
    logic [7:0]                  tmo_q;
    logic                        gnt_vld, gnt_idx;
    logic                        rx_hit, rx_ok, tmo_hit, att_fail, resp_load;

`ifdef LV_OWT_RETRY_EN
    localparam logic [1:0] RETRY_MAX_W = 2'(OWT_RETRY_MAX);
    logic [1:0] retry_q;
    logic       retry_go;
`endif

    lv_rr_arb2 u_rr_arb2 (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_req     ({i_adc_req, i_spi_req}),
        .i_upd_en  (state_q == ST_RESP),
        .i_upd_idx (gnt_q),
        .o_gnt_vld (gnt_vld),
        .o_gnt_idx (gnt_idx)
    );

    // A valid ack always wins over a timeout landing in the same cycle.
    assign rx_hit   = (state_q == ST_WAIT_RX) && i_owt_rx_ack;
    assign rx_ok    = rx_hit && !i_owt_rx_status && (i_owt_rx_cmd == cmd_q);
    assign tmo_hit  = (state_q == ST_WAIT_RX) && (tmo_q == TMO_LAST);
    assign att_fail = (rx_hit && !rx_ok) || (!rx_hit && tmo_hit);
`ifdef LV_OWT_RETRY_EN
    assign retry_go = att_fail && (retry_q < RETRY_MAX_W);
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // NOTE: state_d gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:    if ((i_spi_req || i_adc_req) && !o_spi_done && !o_adc_done)
                            state_d = ST_ARB;
            ST_ARB:     state_d = gnt_vld ? ST_TX : ST_IDLE;
            ST_TX:      if (i_owt_tx_done) state_d = ST_WAIT_RX;
            ST_WAIT_RX: begin
                if (rx_ok) begin
                    state_d = ST_RESP;
                end else if (att_fail) begin
`ifdef LV_OWT_RETRY_EN
                    state_d = retry_go ? ST_TX : ST_RESP;
`else
                    state_d = ST_RESP;
`endif
                end
            end
            ST_RESP:    state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    assign resp_load = (state_q == ST_WAIT_RX) && (state_d == ST_RESP);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cmd_q       <= '0;
            data_q      <= '0;
            gnt_q       <= RR_SPI;
            tmo_q       <= '0;
            o_spi_done  <= 1'b0;
            o_spi_rdata <= '0;
            o_spi_err   <= 1'b0;
            o_adc_done  <= 1'b0;
            o_adc_data  <= '0;
            o_adc_err   <= 1'b0;
        end else begin
            o_spi_done <= 1'b0;
            o_adc_done <= 1'b0;

            if (state_q == ST_ARB && gnt_vld) begin
                gnt_q <= gnt_idx;
                if (gnt_idx == RR_ADC) begin
                    cmd_q  <= OWT_CMD_BIT_NUM'(ADC_POLL_CMD);
                    data_q <= '0;
                end else begin
                    cmd_q  <= i_spi_cmd;
                    data_q <= OWT_ADCD_BIT_NUM'(i_spi_wdata);
                end
            end

            if (state_q == ST_WAIT_RX) begin
                if (tmo_q != 8'hFF) tmo_q <= tmo_q + 8'd1;
            end else begin
                tmo_q <= '0;
            end

            // Failed attempts report zero data so stale RX bits never leak out.
            if (resp_load) begin
                if (gnt_q == RR_SPI) begin
                    o_spi_done  <= 1'b1;
                    o_spi_err   <= !rx_ok;
                    o_spi_rdata <= rx_ok ? i_owt_rx_data[OWT_DATA_BIT_NUM-1:0] : '0;
                end else begin
                    o_adc_done  <= 1'b1;
                    o_adc_err   <= !rx_ok;
                    o_adc_data  <= rx_ok ? i_owt_rx_data : '0;
                end
            end
        end
    end

`ifdef LV_OWT_RETRY_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            retry_q <= '0;
        end else if (state_q == ST_ARB) begin
            retry_q <= '0;
        end else if (retry_go) begin
            retry_q <= retry_q + 2'd1;
        end
    end
`endif

    assign o_owt_tx_req  = (state_q == ST_TX);
    assign o_owt_tx_cmd  = cmd_q;
    assign o_owt_tx_data = data_q;

endmodule

// File: tb/tb_lv_owt_req_arb.sv
// Scoreboard bench for lv_owt_req_arb: expected completions are queued when a
// request is issued and popped by a monitor when a done pulse appears.
module tb_lv_owt_req_arb;

    localparam int TMO = 16;
`ifdef LV_OWT_RETRY_EN
    localparam int  ATTEMPTS = 3;
    localparam bit  RETRY    = 1'b1;
`else
    localparam int  ATTEMPTS = 1;
    localparam bit  RETRY    = 1'b0;
`endif

    logic       clk, rst_n;
    logic       spi_req, adc_req;
    logic [7:0] spi_cmd, spi_wdata;
    logic       spi_done, spi_err, adc_done, adc_err;
    logic [7:0] spi_rdata;
    logic [9:0] adc_data;
    logic       tx_req, tx_done;
    logic [7:0] tx_cmd;
    logic [9:0] tx_data;
    logic       rx_ack, rx_status;
    logic [7:0] rx_cmd;
    logic [9:0] rx_data;

    typedef struct packed {
        logic       is_adc;
        logic       err;
        logic [9:0] data;
    } exp_t;

    typedef struct packed {
        logic [7:0] cmd;
        logic [9:0] data;
    } frm_t;

    exp_t exp_q[$];
    frm_t frm_q[$];
    int   checks   = 0;
    int   failures = 0;

    lv_owt_req_arb #(
        .OWT_CMD_BIT_NUM (8),
        .OWT_DATA_BIT_NUM(8),
        .OWT_ADCD_BIT_NUM(10),
        .OWT_TMO_CYC     (TMO),
        .OWT_RETRY_MAX   (2)
    ) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_spi_req      (spi_req),
        .i_spi_cmd      (spi_cmd),
        .i_spi_wdata    (spi_wdata),
        .o_spi_done     (spi_done),
        .o_spi_rdata    (spi_rdata),
        .o_spi_err      (spi_err),
        .i_adc_req      (adc_req),
        .o_adc_done     (adc_done),
        .o_adc_data     (adc_data),
        .o_adc_err      (adc_err),
        .o_owt_tx_req   (tx_req),
        .o_owt_tx_cmd   (tx_cmd),
        .o_owt_tx_data  (tx_data),
        .i_owt_tx_done  (tx_done),
        .i_owt_rx_ack   (rx_ack),
        .i_owt_rx_status(rx_status),
        .i_owt_rx_cmd   (rx_cmd),
        .i_owt_rx_data  (rx_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired got=running want=finished");
        $fatal(1, "watchdog");
    end

    // Completion / frame monitor, sampled on the falling edge.
    logic prev_spi_done, prev_adc_done, prev_tx_req;
    exp_t mon_e;
    logic mon_adc, mon_err;
    logic [9:0] mon_data;
    frm_t mon_f;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_spi_done = 1'b0;
            prev_adc_done = 1'b0;
            prev_tx_req   = 1'b0;
        end else begin
            if (spi_done || adc_done) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_done spi_done=%0b adc_done=%0b want=none", spi_done, adc_done);
                end else begin
                    mon_e    = exp_q.pop_front();
                    mon_adc  = adc_done;
                    mon_err  = mon_adc ? adc_err : spi_err;
                    mon_data = mon_adc ? adc_data : {2'b00, spi_rdata};
                    if ({mon_adc, mon_err, mon_data} !== mon_e)
                        begin
                            failures++;
                            $display("FAIL completion got adc=%0b err=%0b data=%h want adc=%0b err=%0b data=%h",
                                     mon_adc, mon_err, mon_data, mon_e.is_adc, mon_e.err, mon_e.data);
                        end
                end
                checks++;
                if ((spi_done && prev_spi_done) || (adc_done && prev_adc_done)) begin
                    failures++;
                    $display("FAIL done_width got=2+cycles want=1cycle");
                end
            end
            if (tx_req && !prev_tx_req) begin
                mon_f = {tx_cmd, tx_data};
                frm_q.push_back(mon_f);
            end else if (tx_req) begin
                checks++;
                if ({tx_cmd, tx_data} !== mon_f) begin
                    failures++;
                    $display("FAIL tx_stable got=%h want=%h", {tx_cmd, tx_data}, mon_f);
                end
            end
            prev_spi_done = spi_done;
            prev_adc_done = adc_done;
            prev_tx_req   = tx_req;
        end
    end

    task automatic push_exp(input logic adc, input logic err, input logic [9:0] d);
        exp_q.push_back({adc, err, d});
    endtask

    task automatic idle_inputs();
        spi_req = 0; adc_req = 0; spi_cmd = 0; spi_wdata = 0;
        tx_done = 0; rx_ack = 0; rx_status = 0; rx_cmd = 0; rx_data = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        exp_q.delete();
        frm_q.delete();
    endtask

    // Acts as the one-wire PHY: waits for a frame, completes TX, optionally acks.
    task automatic serve(input int tx_dly, input bit do_ack, input bit status,
                         input bit bad_cmd, input logic [9:0] rdata, input int ack_dly);
        bit got;
        logic [7:0] cmd;
        got = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (tx_req) begin
                got = 1'b1;
                break;
            end
        end
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL tx_req_wait got=0 want=1");
            return;
        end
        cmd = tx_cmd;
        repeat (tx_dly) @(negedge clk);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        if (do_ack) begin
            repeat (ack_dly) @(negedge clk);
            rx_ack    = 1'b1;
            rx_status = status;
            rx_cmd    = bad_cmd ? ~cmd : cmd;
            rx_data   = rdata;
            @(negedge clk);
            rx_ack = 1'b0; rx_status = 1'b0; rx_cmd = '0; rx_data = '0;
        end
    endtask

    task automatic wait_done(input int budget, output bit seen, output int cyc);
        seen = 1'b0;
        cyc  = 0;
        for (int i = 0; i < budget; i++) begin
            if (spi_done || adc_done) begin
                seen = 1'b1;
                cyc  = i;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({spi_done, spi_rdata, spi_err, adc_done, adc_data, adc_err, tx_req, tx_cmd, tx_data} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got=nonzero want=0");
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        checks++;
        if ({spi_done, adc_done, tx_req} !== 3'b000) begin
            failures++;
            $display("FAIL idle_after_reset got=%b want=000", {spi_done, adc_done, tx_req});
        end
    endtask

    task automatic test_spi_basic();
        bit seen; int cyc;
        frm_q.delete();
        push_exp(1'b0, 1'b0, 10'h0C7);
        spi_cmd = 8'h85; spi_wdata = 8'h3C; spi_req = 1'b1;
        serve(40, 1'b1, 1'b0, 1'b0, 10'h3C7, 3);
        wait_done(20, seen, cyc);
        spi_req = 1'b0;
        checks++;
        if (!seen) begin failures++; $display("FAIL spi_basic_done got=0 want=1"); end
        @(negedge clk);
        checks++;
        if (frm_q.size() != 1 || frm_q[0] !== {8'h85, 10'h03C}) begin
            failures++;
            $display("FAIL spi_basic_frame got_n=%0d want_n=1 want=%h", frm_q.size(), {8'h85, 10'h03C});
        end
    endtask

    task automatic test_adc();
        bit seen; int cyc;
        frm_q.delete();
        push_exp(1'b1, 1'b0, 10'h2A5);
        adc_req = 1'b1;
        serve(5, 1'b1, 1'b0, 1'b0, 10'h2A5, 3);
        wait_done(20, seen, cyc);
        adc_req = 1'b0;
        checks++;
        if (!seen) begin failures++; $display("FAIL adc_done got=0 want=1"); end
        @(negedge clk);
        checks++;
        if (frm_q.size() != 1 || frm_q[0] !== {8'h1F, 10'h000}) begin
            failures++;
            $display("FAIL adc_frame got_n=%0d want_n=1 want=%h", frm_q.size(), {8'h1F, 10'h000});
        end
        checks++;
        if (spi_rdata !== 8'hC7) begin
            failures++;
            $display("FAIL spi_rdata_hold got=%h want=c7", spi_rdata);
        end
    endtask

    task automatic test_round_robin();
        bit seen; int cyc;
        frm_t want;
        do_reset();
        push_exp(1'b0, 1'b0, 10'h001);
        push_exp(1'b1, 1'b0, 10'h102);
        push_exp(1'b0, 1'b0, 10'h003);
        push_exp(1'b1, 1'b0, 10'h104);
        spi_cmd = 8'hA4; spi_wdata = 8'h11;
        spi_req = 1'b1; adc_req = 1'b1;
        for (int i = 1; i <= 4; i++) serve(2, 1'b1, 1'b0, 1'b0, 10'h100 + 10'(i), 2);
        wait_done(20, seen, cyc);
        spi_req = 1'b0; adc_req = 1'b0;
        checks++;
        if (!seen) begin failures++; $display("FAIL rr_last_done got=0 want=1"); end
        @(negedge clk);
        checks++;
        if (frm_q.size() != 4) begin
            failures++;
            $display("FAIL rr_frame_count got=%0d want=4", frm_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                want = (i % 2 == 0) ? {8'hA4, 10'h011} : {8'h1F, 10'h000};
                checks++;
                if (frm_q[i] !== want) begin
                    failures++;
                    $display("FAIL rr_frame%0d got=%h want=%h", i, frm_q[i], want);
                end
            end
        end
    endtask

    task automatic test_timeout();
        bit seen; int cyc;
        frm_q.delete();
        push_exp(1'b0, 1'b1, 10'h000);
        spi_cmd = 8'h02; spi_wdata = 8'h00; spi_req = 1'b1;
        for (int a = 0; a < ATTEMPTS; a++) serve(2, 1'b0, 1'b0, 1'b0, 10'h000, 0);
        wait_done(60, seen, cyc);
        spi_req = 1'b0;
        checks++;
        if (!seen || cyc != TMO) begin
            failures++;
            $display("FAIL timeout_latency got_seen=%0b got_cyc=%0d want_cyc=%0d", seen, cyc, TMO);
        end
        @(negedge clk);
        checks++;
        if (frm_q.size() != ATTEMPTS) begin
            failures++;
            $display("FAIL timeout_frames got=%0d want=%0d", frm_q.size(), ATTEMPTS);
        end
    endtask

    task automatic test_status_err();
        bit seen; int cyc;
        frm_q.delete();
        if (RETRY) push_exp(1'b0, 1'b0, 10'h05A);
        else       push_exp(1'b0, 1'b1, 10'h000);
        spi_cmd = 8'h07; spi_wdata = 8'h00; spi_req = 1'b1;
        serve(2, 1'b1, 1'b1, 1'b0, 10'h0FF, 3);
        if (RETRY) serve(2, 1'b1, 1'b0, 1'b0, 10'h05A, 3);
        wait_done(40, seen, cyc);
        spi_req = 1'b0;
        checks++;
        if (!seen) begin failures++; $display("FAIL status_done got=0 want=1"); end
        @(negedge clk);
        checks++;
        if (frm_q.size() != (RETRY ? 2 : 1)) begin
            failures++;
            $display("FAIL status_frames got=%0d want=%0d", frm_q.size(), RETRY ? 2 : 1);
        end
    endtask

    task automatic test_cmd_mismatch();
        bit seen; int cyc;
        frm_q.delete();
        push_exp(1'b1, 1'b1, 10'h000);
        adc_req = 1'b1;
        for (int a = 0; a < ATTEMPTS; a++) serve(1, 1'b1, 1'b0, 1'b1, 10'h0AA, 2);
        wait_done(40, seen, cyc);
        adc_req = 1'b0;
        checks++;
        if (!seen) begin failures++; $display("FAIL mismatch_done got=0 want=1"); end
        @(negedge clk);
        checks++;
        if (frm_q.size() != ATTEMPTS) begin
            failures++;
            $display("FAIL mismatch_frames got=%0d want=%0d", frm_q.size(), ATTEMPTS);
        end
    endtask

    task automatic test_ack_at_timeout();
        bit seen; int cyc;
        push_exp(1'b0, 1'b0, 10'h0E1);
        spi_cmd = 8'h11; spi_wdata = 8'h22; spi_req = 1'b1;
        serve(2, 1'b1, 1'b0, 1'b0, 10'h0E1, TMO - 1);
        wait_done(20, seen, cyc);
        spi_req = 1'b0;
        checks++;
        if (!seen) begin failures++; $display("FAIL ack_tmo_done got=0 want=1"); end
        @(negedge clk);
    endtask

    task automatic test_ignore_idle();
        frm_q.delete();
        tx_done = 1'b1; rx_ack = 1'b1; rx_cmd = 8'h11; rx_data = 10'h3FF;
        @(negedge clk);
        tx_done = 1'b0; rx_ack = 1'b0; rx_cmd = '0; rx_data = '0;
        repeat (6) @(negedge clk);
        checks++;
        if (tx_req !== 1'b0 || frm_q.size() != 0) begin
            failures++;
            $display("FAIL ignore_idle got_tx=%0b got_frames=%0d want=0", tx_req, frm_q.size());
        end
    endtask

    task automatic test_drop_mid();
        bit seen; int cyc;
        bit got;
        push_exp(1'b0, 1'b0, 10'h066);
        spi_cmd = 8'h33; spi_wdata = 8'h44; spi_req = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (tx_req) begin got = 1'b1; break; end
        end
        spi_req = 1'b0;
        checks++;
        if (!got) begin failures++; $display("FAIL drop_tx_req got=0 want=1"); end
        serve(3, 1'b1, 1'b0, 1'b0, 10'h066, 2);
        wait_done(20, seen, cyc);
        checks++;
        if (!seen) begin failures++; $display("FAIL drop_done got=0 want=1"); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        bit seen; int cyc;
        int stray;
        spi_cmd = 8'h85; spi_wdata = 8'h01; spi_req = 1'b1;
        serve(2, 1'b0, 1'b0, 1'b0, 10'h000, 0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({spi_done, spi_rdata, spi_err, adc_done, adc_data, adc_err, tx_req, tx_cmd, tx_data} !== '0) begin
            failures++;
            $display("FAIL reset_mid_outputs got=nonzero want=0");
        end
        spi_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        stray = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (spi_done || adc_done) stray++;
        end
        checks++;
        if (stray != 0) begin failures++; $display("FAIL reset_mid_stray got=%0d want=0", stray); end
        frm_q.delete();
        push_exp(1'b0, 1'b0, 10'h099);
        spi_cmd = 8'h86; spi_wdata = 8'h55; spi_req = 1'b1;
        serve(2, 1'b1, 1'b0, 1'b0, 10'h199, 2);
        wait_done(20, seen, cyc);
        spi_req = 1'b0;
        checks++;
        if (!seen) begin failures++; $display("FAIL reset_mid_recover got=0 want=1"); end
        @(negedge clk);
        checks++;
        if (frm_q.size() != 1 || frm_q[0] !== {8'h86, 10'h055}) begin
            failures++;
            $display("FAIL reset_mid_frame got_n=%0d want=%h", frm_q.size(), {8'h86, 10'h055});
        end
    endtask

    initial begin
        test_reset();
        test_spi_basic();
        test_adc();
        test_round_robin();
        test_timeout();
        test_status_err();
        test_cmd_mismatch();
        test_ack_at_timeout();
        test_ignore_idle();
        test_drop_mid();
        test_reset_mid();
        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got=%0d want=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
